// File: rtl/euler_row_sequencer.sv
// ============================================================================
//  Module      : euler_row_sequencer
//  Description : Sequences one Euler-integration run over the row-wise
//                datapath. Each step issues rows 0..num_rows-1 to the row
//                MAC engine (request/ack, then end-of-row), then requests the
//                state update x += h*dx. Repeats for num_steps steps.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: EULER_SEQ_ABORT_EN
//    When defined, adds input abort and output aborted. abort in any busy
//    state (other than FIN) ends the run through FIN with a done pulse,
//    freezing step_cnt and dropping any outstanding request.
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   clock, rising edge
//    rst_async_n  in   asynchronous reset, active low
//    rst_sync     in   synchronous clear, active high (same effect as reset)
//    start        in   start a run (sampled only in IDLE)
//    num_rows     in   rows per step, latched on accepted start
//    num_steps    in   steps per run, latched on accepted start
//    row_req      out  row issue request, held until row_ack
//    row_idx      out  row being issued/processed
//    row_ack      in   row engine accepted row_idx
//    row_done     in   row engine finished current row
//    upd_req      out  one-cycle pulse: apply the Euler update for this step
//    upd_done     in   state update written back
//    step_cnt     out  completed steps in the current/last run
//    busy         out  high in every state except IDLE
//    done         out  one-cycle pulse at end of run
//    cfg_err      out  last start had a zero row or step count
//    abort        in   (EULER_SEQ_ABORT_EN) abort the current run
//    aborted      out  (EULER_SEQ_ABORT_EN) last run was aborted
// ============================================================================
`default_nettype none

module euler_row_sequencer #(
  parameter int ROW_W  = 8,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst_async_n,
  input  logic              rst_sync,
  input  logic              start,
  input  logic [ROW_W-1:0]  num_rows,
  input  logic [STEP_W-1:0] num_steps,
  output logic              row_req,
  output logic [ROW_W-1:0]  row_idx,
  input  logic              row_ack,
  input  logic              row_done,
  output logic              upd_req,
  input  logic              upd_done,
  output logic [STEP_W-1:0] step_cnt,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
`ifdef EULER_SEQ_ABORT_EN
  ,
  input  logic              abort,
  output logic              aborted
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_ROW = 3'd2,
    UPDATE   = 3'd3,
    WAIT_UPD = 3'd4,
    FIN      = 3'd5
  } state_t;

  state_t            state;
  logic [ROW_W-1:0]  rows_cfg;
  logic [STEP_W-1:0] steps_cfg;

  logic              abort_hit;
  logic              row_complete;
  logic              last_row;
  logic              last_step;
  logic [STEP_W-1:0] step_cnt_inc;

`ifdef EULER_SEQ_ABORT_EN
  // FIN is already on its way back to IDLE, so abort there changes nothing.
  assign abort_hit = abort && (state != IDLE) && (state != FIN);
`else
  assign abort_hit = 1'b0;
`endif

  // A row completes on row_done in WAIT_ROW, or on ack+done together in ISSUE.
  assign row_complete = row_done && ((state == WAIT_ROW) || ((state == ISSUE) && row_ack));

  // rows_cfg is never zero while a row is in flight, so the subtraction
  // cannot wrap during a run.
  assign last_row     = (row_idx == (rows_cfg - ROW_W'(1)));
  assign step_cnt_inc = step_cnt + STEP_W'(1);
  assign last_step    = (step_cnt_inc == steps_cfg);

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state     <= IDLE;
      rows_cfg  <= '0;
      steps_cfg <= '0;
      row_req   <= 1'b0;
      row_idx   <= '0;
      upd_req   <= 1'b0;
      step_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
`ifdef EULER_SEQ_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else if (rst_sync) begin
      state     <= IDLE;
      rows_cfg  <= '0;
      steps_cfg <= '0;
      row_req   <= 1'b0;
      row_idx   <= '0;
      upd_req   <= 1'b0;
      step_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
`ifdef EULER_SEQ_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; states that need them re-assert.
      done    <= 1'b0;
      upd_req <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            rows_cfg  <= num_rows;
            steps_cfg <= num_steps;
            row_idx   <= '0;
            step_cnt  <= '0;
            busy      <= 1'b1;
`ifdef EULER_SEQ_ABORT_EN
            aborted   <= 1'b0;
`endif
            if ((num_rows == '0) || (num_steps == '0)) begin
              cfg_err <= 1'b1;
              state   <= FIN;
            end else begin
              cfg_err <= 1'b0;
              row_req <= 1'b1;
              state   <= ISSUE;
            end
          end
        end

        ISSUE, WAIT_ROW: begin
          if (abort_hit) begin
            row_req <= 1'b0;
            state   <= FIN;
`ifdef EULER_SEQ_ABORT_EN
            aborted <= 1'b1;
`endif
          end else if (row_complete) begin
            if (!last_row) begin
              row_idx <= row_idx + ROW_W'(1);
              row_req <= 1'b1;
              state   <= ISSUE;
            end else begin
              // upd_req is set on entry so it is high exactly while in UPDATE.
              row_req <= 1'b0;
              upd_req <= 1'b1;
              state   <= UPDATE;
            end
          end else if ((state == ISSUE) && row_ack) begin
            row_req <= 1'b0;
            state   <= WAIT_ROW;
          end
        end

        UPDATE: begin
          if (abort_hit) begin
            state   <= FIN;
`ifdef EULER_SEQ_ABORT_EN
            aborted <= 1'b1;
`endif
          end else begin
            state <= WAIT_UPD;
          end
        end

        WAIT_UPD: begin
          if (abort_hit) begin
            state   <= FIN;
`ifdef EULER_SEQ_ABORT_EN
            aborted <= 1'b1;
`endif
          end else if (upd_done) begin
            step_cnt <= step_cnt_inc;
            if (last_step) begin
              state <= FIN;
            end else begin
              row_idx <= '0;
              row_req <= 1'b1;
              state   <= ISSUE;
            end
          end
        end

        FIN: begin
          // done is registered out of FIN, so it coincides with the first
          // IDLE cycle (busy already low).
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          row_req <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
